// File: rtl/checkpoint_mon_pkg.sv
// Shared fail codes and FSM state encoding for the checkpoint sequence monitor.
package checkpoint_mon_pkg;

    localparam logic [1:0] FC_NONE   = 2'b00;
    localparam logic [1:0] FC_TMO    = 2'b01;
    localparam logic [1:0] FC_STRICT = 2'b10;
    localparam logic [1:0] FC_CFG    = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL
    } state_e;

endpackage

// File: rtl/checkpoint_sync_filter.sv
// Two-flop synchroniser plus stability filter; pulses stable_new once per
// new value that held for STABLE_N consecutive cycles.
module checkpoint_sync_filter #(
    parameter int DATA_W   = 16,
    parameter int STABLE_N = 4
) (
    input  logic              clock,
    input  logic              resetb,
    input  logic [DATA_W-1:0] probe,
    output logic [DATA_W-1:0] last_val,
    output logic              stable_new
);

    localparam int CW = $clog2(STABLE_N + 1);
    localparam logic [CW-1:0] CMAX = CW'(STABLE_N);

    logic [DATA_W-1:0] sync1_q, sync2_q, cand_q, last_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              new_q, fire;

    always_comb begin
        cnt_d = cnt_q;
        if (sync2_q != cand_q) begin
            cnt_d = CW'(1);
        end else if (cnt_q != CMAX) begin
            cnt_d = cnt_q + CW'(1);
        end
        // A value equal to the current stable one never re-fires.
        fire = (cnt_d == CMAX) && (sync2_q != last_q);
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
            last_q  <= '0;
            new_q   <= 1'b0;
        end else begin
            sync1_q <= probe;
            sync2_q <= sync1_q;
            cand_q  <= sync2_q;
            cnt_q   <= cnt_d;
            new_q   <= fire;
            if (fire) begin
                last_q <= sync2_q;
            end
        end
    end

    assign last_val   = last_q;
    assign stable_new = new_q;

endmodule

// File: rtl/checkpoint_seq_monitor.sv
// Matches an ordered table of checkpoint values on a filtered probe bus,
// with per-step timeout and optional strict mismatch detection.
module checkpoint_seq_monitor
    import checkpoint_mon_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 8,
    parameter int STABLE_N = 4,
    parameter int TMO_W    = 24
) (
    input  logic                       clock,
    input  logic                       resetb,
    input  logic [DATA_W-1:0]          probe,
    input  logic                       cfg_we,
    input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
    input  logic [DATA_W-1:0]          cfg_data,
    input  logic [$clog2(DEPTH):0]     cfg_len,
    input  logic [TMO_W-1:0]           cfg_tmo,
    input  logic                       cfg_strict,
    input  logic                       start,
    input  logic                       abort,
    output logic                       busy,
    output logic                       step_hit,
    output logic [$clog2(DEPTH)-1:0]   step_idx,
    output logic                       pass,
    output logic                       fail,
    output logic [1:0]                 fail_code,
    output logic [DATA_W-1:0]          last_val
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] sval;
    logic              stable_new;

    checkpoint_sync_filter #(
        .DATA_W   (DATA_W),
        .STABLE_N (STABLE_N)
    ) u_filter (
        .clock      (clock),
        .resetb     (resetb),
        .probe      (probe),
        .last_val   (sval),
        .stable_new (stable_new)
    );

    logic [DATA_W-1:0] tbl_q [DEPTH];
    state_e            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [TMO_W-1:0]  tcnt_q, tcnt_d, tmo_q, tmo_d;
    logic [LW-1:0]     len_q, len_d;
    logic [DATA_W-1:0] base_q, base_d;
    logic              strict_q, strict_d;
    logic              hit_q, hit_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic [1:0]        fc_q, fc_d;

    logic [DATA_W-1:0] exp_val, prev_val;
    logic              is_last, tmo_hit, len_bad;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= '0;
            end
        end else if (cfg_we && state_q != S_RUN) begin
            tbl_q[cfg_addr] <= cfg_data;
        end
    end

    always_comb begin
        exp_val  = tbl_q[idx_q];
        prev_val = (idx_q == '0) ? base_q : tbl_q[idx_q - AW'(1)];
        is_last  = ({1'b0, idx_q} == len_q - LW'(1));
        tmo_hit  = (tmo_q != '0) && (tcnt_q == tmo_q - TMO_W'(1));
        len_bad  = (cfg_len == '0) || (cfg_len > LW'(DEPTH));
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tcnt_d   = tcnt_q;
        tmo_d    = tmo_q;
        len_d    = len_q;
        base_d   = base_q;
        strict_d = strict_q;
        hit_d    = 1'b0;
        pass_d   = pass_q;
        fail_d   = fail_q;
        fc_d     = fc_q;
        if (abort) begin
            state_d = S_IDLE;
            idx_d   = '0;
            tcnt_d  = '0;
            pass_d  = 1'b0;
            fail_d  = 1'b0;
            fc_d    = FC_NONE;
        end else begin
            unique case (state_q)
                S_IDLE, S_PASS, S_FAIL: begin
                    if (start && len_bad) begin
                        state_d = S_FAIL;
                        idx_d   = '0;
                        pass_d  = 1'b0;
                        fail_d  = 1'b1;
                        fc_d    = FC_CFG;
                    end else if (start) begin
                        state_d  = S_RUN;
                        idx_d    = '0;
                        tcnt_d   = '0;
                        pass_d   = 1'b0;
                        fail_d   = 1'b0;
                        fc_d     = FC_NONE;
                        len_d    = cfg_len;
                        tmo_d    = cfg_tmo;
                        strict_d = cfg_strict;
                        base_d   = sval;
                    end
                end
                S_RUN: begin
                    // Priority: match, then strict mismatch, then timeout.
                    if (stable_new && sval == exp_val) begin
                        hit_d  = 1'b1;
                        tcnt_d = '0;
                        if (is_last) begin
                            state_d = S_PASS;
                            pass_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + AW'(1);
                        end
                    end else if (stable_new && strict_q && sval != prev_val) begin
                        state_d = S_FAIL;
                        fail_d  = 1'b1;
                        fc_d    = FC_STRICT;
                    end else if (tmo_hit) begin
                        state_d = S_FAIL;
                        fail_d  = 1'b1;
                        fc_d    = FC_TMO;
                    end else if (tcnt_q != '1) begin
                        tcnt_d = tcnt_q + TMO_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            tcnt_q   <= '0;
            tmo_q    <= '0;
            len_q    <= '0;
            base_q   <= '0;
            strict_q <= 1'b0;
            hit_q    <= 1'b0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
            fc_q     <= FC_NONE;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            tcnt_q   <= tcnt_d;
            tmo_q    <= tmo_d;
            len_q    <= len_d;
            base_q   <= base_d;
            strict_q <= strict_d;
            hit_q    <= hit_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            fc_q     <= fc_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign step_hit  = hit_q;
    assign step_idx  = idx_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign fail_code = fc_q;
    assign last_val  = sval;

endmodule

// File: tb/tb_checkpoint_seq_monitor.sv
// Directed bench for checkpoint_seq_monitor with a step-value scoreboard.
module tb_checkpoint_seq_monitor;

    logic        clock = 1'b0;
    logic        resetb;
    logic [15:0] probe;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic [3:0]  cfg_len;
    logic [23:0] cfg_tmo;
    logic        cfg_strict;
    logic        start;
    logic        abort;
    logic        busy;
    logic        step_hit;
    logic [2:0]  step_idx;
    logic        pass;
    logic        fail;
    logic [1:0]  fail_code;
    logic [15:0] last_val;

    int          tests = 0;
    int          fails = 0;
    int          hits  = 0;
    int          h0;
    logic [15:0] expq[$];
    logic [15:0] seqv [4];

    checkpoint_seq_monitor dut (
        .clock      (clock),
        .resetb     (resetb),
        .probe      (probe),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_len    (cfg_len),
        .cfg_tmo    (cfg_tmo),
        .cfg_strict (cfg_strict),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .step_hit   (step_hit),
        .step_idx   (step_idx),
        .pass       (pass),
        .fail       (fail),
        .fail_code  (fail_code),
        .last_val   (last_val)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        cyc(1);
        cfg_we   = 1'b0;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic drive(input logic [15:0] v, input bit exp_hit,
                         input int n);
        probe = v;
        if (exp_hit) expq.push_back(v);
        cyc(n);
    endtask

    initial begin
        seqv[0] = 16'h003E;
        seqv[1] = 16'h0044;
        seqv[2] = 16'h004A;
        seqv[3] = 16'h0050;
        resetb = 1'b0; probe = '0; cfg_we = 0; cfg_addr = '0;
        cfg_data = '0; cfg_len = '0; cfg_tmo = '0; cfg_strict = 0;
        start = 0; abort = 0;

        fork
            forever begin
                @(negedge clock);
                if (step_hit) begin
                    hits++;
                    if (expq.size() == 0)
                        check("unexpected_hit", {16'h0, last_val}, 32'hFFFF_FFFF);
                    else
                        check("hit_val", {16'h0, last_val}, {16'h0, expq.pop_front()});
                end
            end
        join_none

        cyc(3);
        check("rst_busy", busy, 0);
        check("rst_pass", pass, 0);
        check("rst_fail", fail, 0);
        check("rst_code", fail_code, 0);
        check("rst_idx", step_idx, 0);
        check("rst_last", last_val, 0);
        resetb = 1'b1;
        cyc(2);

        for (int i = 0; i < 4; i++) wr(3'(i), seqv[i]);

        // Full sequence with latency check on the first step
        cfg_len = 4; cfg_tmo = 1000; cfg_strict = 1;
        h0 = hits;
        pulse_start();
        check("seq_busy", busy, 1);
        check("seq_idx0", step_idx, 0);
        drive(seqv[0], 1, 6);
        check("lat_before", step_hit, 0);
        cyc(1);
        check("lat_hit", step_hit, 1);
        cyc(3);
        check("seq_idx1", step_idx, 1);
        for (int i = 1; i < 4; i++) begin
            drive(seqv[i], 1, 10);
            if (i < 3) check("seq_idx", step_idx, 32'(i + 1));
        end
        check("seq_hits", hits - h0, 4);
        check("seq_pass", pass, 1);
        check("seq_fail", fail, 0);
        check("seq_busy_end", busy, 0);

        // Glitch while 003E awaited, then abort at step 2
        h0 = hits;
        pulse_start();
        drive(16'h0044, 0, 2);
        drive(16'h0050, 0, 15);
        check("glitch_hits", hits - h0, 0);
        check("glitch_fail", fail, 0);
        check("glitch_busy", busy, 1);
        drive(16'h003E, 1, 10);
        drive(16'h0044, 1, 10);
        check("abort_idx_pre", step_idx, 2);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_idx", step_idx, 0);
        check("abort_pass", pass, 0);
        check("abort_fail", fail, 0);
        check("abort_code", fail_code, 0);

        // Timeout exactly 50 cycles after start
        cfg_tmo = 50;
        pulse_start();
        cyc(49);
        check("tmo_early", fail, 0);
        cyc(1);
        check("tmo_fail", fail, 1);
        check("tmo_code", fail_code, 1);
        check("tmo_busy", busy, 0);

        // Strict mismatch
        cfg_tmo = 1000;
        pulse_start();
        drive(16'h003E, 1, 10);
        drive(16'h1234, 0, 10);
        check("strict_fail", fail, 1);
        check("strict_code", fail_code, 2);
        check("strict_pass", pass, 0);

        // Non-strict: mismatch ignored, table frozen while running
        cfg_strict = 0;
        pulse_start();
        drive(16'h003E, 1, 10);
        drive(16'h1234, 0, 10);
        check("lax_fail", fail, 0);
        check("lax_busy", busy, 1);
        drive(16'h0044, 1, 10);
        check("lax_idx", step_idx, 2);
        wr(3'd2, 16'hFFFF);
        drive(16'h004A, 1, 10);
        drive(16'h0050, 1, 10);
        check("frozen_pass", pass, 1);

        // Bad lengths
        cfg_len = 0;
        pulse_start();
        check("len0_fail", fail, 1);
        check("len0_code", fail_code, 3);
        check("len0_pass", pass, 0);
        check("len0_busy", busy, 0);
        cfg_len = 9;
        pulse_start();
        check("len9_code", fail_code, 3);

        // Asynchronous reset mid-run
        cfg_len = 4;
        pulse_start();
        drive(16'h003E, 1, 10);
        check("mid_idx", step_idx, 1);
        #2 resetb = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_idx", step_idx, 0);
        check("arst_pass", pass, 0);
        check("arst_fail", fail, 0);
        check("arst_last", last_val, 0);
        #2 resetb = 1'b1;
        cyc(2);
        check("queue_empty", expq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
